// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue with delay-slot tracking for taken branches,
// branch-likely nullification and flush; redirects IF when a delay slot is secured.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_Inst,
  input  logic [31:0]                in_PC4,
  input  logic                       in_exception,
  input  logic [EXC_W-1:0]           in_ExcCode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_Inst,
  output logic [31:0]                out_PC4,
  output logic                       out_exception,
  output logic [EXC_W-1:0]           out_ExcCode,
  output logic                       out_BD,
  input  logic                       branch_taken,
  input  logic                       nullify_ds,
  input  logic [31:0]                branch_target,
  input  logic                       flush,
  output logic                       fetch_redirect,
  output logic [31:0]                redirect_target,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]      inst;
    logic [31:0]      pc4;
    logic             exc;
    logic [EXC_W-1:0] code;
  } ent_t;

  typedef enum logic [1:0] {RUN, WAIT_DS, WAIT_NULL} state_t;

  ent_t             mem [DEPTH];
  state_t           state_q, state_d;
  logic [PW-1:0]    head_q, head_d, head_p1, tail;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [DEPTH-1:0] bd_q, bd_d;
  logic             pop, push, wr_en, wr_bd;

  // Tail is implied by head + occupancy; a full queue wraps back onto head.
  assign tail      = head_q + count_q[PW-1:0];
  assign head_p1   = head_q + PW'(1);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = (state_q != RUN) | (count_q < CW'(DEPTH)) | pop;
  assign push      = in_valid & in_ready;
  assign count     = count_q;

  assign out_Inst        = mem[head_q].inst;
  assign out_PC4         = mem[head_q].pc4;
  assign out_exception   = mem[head_q].exc;
  assign out_ExcCode     = mem[head_q].code;
  assign out_BD          = out_valid & bd_q[head_q];
  assign redirect_target = (state_q == WAIT_DS) ? tgt_q : branch_target;

  always_comb begin
    head_d         = head_q;
    count_d        = count_q;
    state_d        = state_q;
    tgt_d          = tgt_q;
    bd_d           = bd_q;
    wr_en          = 1'b0;
    wr_bd          = 1'b0;
    fetch_redirect = 1'b0;
    if (flush) begin
      head_d  = '0;
      count_d = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (pop & branch_taken) begin
            head_d = head_p1;
            if (count_q >= CW'(2)) begin
              count_d       = CW'(1);
              bd_d[head_p1] = 1'b1;
              fetch_redirect = 1'b1;
            end else if (push) begin
              // Single-entry queue: this cycle's push lands at head_p1 as the slot.
              count_d        = CW'(1);
              wr_en          = 1'b1;
              wr_bd          = 1'b1;
              fetch_redirect = 1'b1;
            end else begin
              count_d = '0;
              tgt_d   = branch_target;
              state_d = WAIT_DS;
            end
          end else if (pop & nullify_ds) begin
            if (count_q >= CW'(2)) begin
              head_d  = head_q + PW'(2);
              count_d = count_q - CW'(2) + CW'(push);
              wr_en   = push;
            end else begin
              head_d  = head_p1;
              count_d = '0;
              if (!push) state_d = WAIT_NULL;
            end
          end else begin
            head_d  = head_q + PW'(pop);
            count_d = count_q + CW'(push) - CW'(pop);
            wr_en   = push;
          end
        end
        WAIT_DS: if (push) begin
          wr_en          = 1'b1;
          wr_bd          = 1'b1;
          count_d        = CW'(1);
          fetch_redirect = 1'b1;
          state_d        = RUN;
        end
        WAIT_NULL: if (push) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
    if (wr_en) bd_d[tail] = wr_bd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      head_q  <= '0;
      count_q <= '0;
      tgt_q   <= '0;
      bd_q    <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      bd_q    <= bd_d;
    end
  end

  // Payload storage is not reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= '{inst: in_Inst, pc4: in_PC4, exc: in_exception, code: in_ExcCode};
  end
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: queue-level reference model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int EXC_W = 5;

  logic        clk = 0, reset = 0;
  logic        in_valid = 0, in_ready, in_exception = 0;
  logic [31:0] in_Inst = 0, in_PC4 = 0, branch_target = 0;
  logic [4:0]  in_ExcCode = 0;
  logic        out_valid, out_ready = 0, out_exception, out_BD;
  logic [31:0] out_Inst, out_PC4, redirect_target;
  logic [4:0]  out_ExcCode;
  logic        branch_taken = 0, nullify_ds = 0, flush = 0, fetch_redirect;
  logic [2:0]  count;

  decode_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_Inst(in_Inst), .in_PC4(in_PC4), .in_exception(in_exception), .in_ExcCode(in_ExcCode),
    .out_valid(out_valid), .out_ready(out_ready), .out_Inst(out_Inst), .out_PC4(out_PC4),
    .out_exception(out_exception), .out_ExcCode(out_ExcCode), .out_BD(out_BD),
    .branch_taken(branch_taken), .nullify_ds(nullify_ds), .branch_target(branch_target),
    .flush(flush), .fetch_redirect(fetch_redirect), .redirect_target(redirect_target),
    .count(count));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, pc4;
    logic        exc;
    logic [4:0]  code;
    logic        bd;
  } m_t;

  m_t          q[$];
  int          mst = 0;       // 0 run, 1 awaiting delay slot, 2 awaiting nullified slot
  logic [31:0] mtgt = 0;
  int          total = 0, bad = 0;
  logic        last_fr;
  logic [31:0] last_rt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step();
    m_t nq[$], e;
    int n, ns;
    logic pop, push, rdy, fr;
    logic [31:0] rt;
    nq = q; n = q.size(); ns = mst; fr = 0; rt = 0;
    pop  = (n != 0) && out_ready;
    rdy  = (mst != 0) || (n < DEPTH) || pop;
    push = in_valid && rdy;
    e = '{inst: in_Inst, pc4: in_PC4, exc: in_exception, code: in_ExcCode, bd: 1'b0};
    if (flush) begin
      nq.delete(); ns = 0;
    end else if (mst == 0) begin
      if (pop && branch_taken) begin
        void'(nq.pop_front());
        if (nq.size() > 0) begin
          e = nq[0]; e.bd = 1; nq.delete(); nq.push_back(e); fr = 1; rt = branch_target;
        end else if (push) begin
          e.bd = 1; nq.push_back(e); fr = 1; rt = branch_target;
        end else begin
          ns = 1; mtgt = branch_target;
        end
      end else if (pop && nullify_ds) begin
        void'(nq.pop_front());
        if (nq.size() > 0) begin
          void'(nq.pop_front());
          if (push) nq.push_back(e);
        end else if (!push) ns = 2;
      end else begin
        if (pop) void'(nq.pop_front());
        if (push) nq.push_back(e);
      end
    end else if (mst == 1) begin
      if (push) begin e.bd = 1; nq.push_back(e); fr = 1; rt = mtgt; ns = 0; end
    end else if (push) ns = 0;

    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, n != 0);
    chk("count", count, n);
    chk("fetch_redirect", fetch_redirect, fr);
    if (fr) chk("redirect_target", redirect_target, rt);
    if (n != 0) begin
      chk("out_PC4", out_PC4, q[0].pc4);
      chk("out_Inst", out_Inst, q[0].inst);
      chk("out_exc", {out_exception, out_ExcCode}, {q[0].exc, q[0].code});
      chk("out_BD", out_BD, q[0].bd);
    end
    last_fr = fetch_redirect; last_rt = redirect_target;
    q = nq; mst = ns;
  endtask

  task automatic cyc(input logic iv, input logic [31:0] pc4, input logic ordy,
                     input logic bt, input logic nd, input logic fl, input logic [31:0] tgt);
    @(negedge clk);
    in_valid = iv; in_PC4 = pc4; in_Inst = pc4 ^ 32'hA5A5_0000;
    in_exception = pc4[2]; in_ExcCode = pc4[6:2];
    out_ready = ordy; branch_taken = bt; nullify_ds = nd; flush = fl; branch_target = tgt;
    #1 model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input logic [31:0] pc4); cyc(1, pc4, 0, 0, 0, 0, 0); endtask
  task automatic pop1();                        cyc(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic idle();                        cyc(0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_fr", fetch_redirect, 0);
    chk("rst_out_BD", out_BD, 0);
    @(negedge clk); reset = 1;

    // Fill beyond capacity, then pop+push at full
    for (int i = 0; i < 5; i++) push1(32'h1004 + 4*i);
    chk("fill_count", count, 4);
    chk("fill_ready", in_ready, 0);
    cyc(1, 32'h1018, 1, 0, 0, 0, 0);
    chk("full_pp_count", count, 4);
    chk("full_pp_head", out_PC4, 32'h1008);
    repeat (4) pop1();

    // Taken branch with delay slot already queued
    push1(32'h3004); push1(32'h3008); push1(32'h300C);
    cyc(0, 0, 1, 1, 0, 0, 32'h4000);
    chk("br_fr", last_fr, 1);
    chk("br_rt", last_rt, 32'h4000);
    chk("br_head", out_PC4, 32'h3008);
    chk("br_bd", out_BD, 1);
    chk("br_count", count, 1);
    pop1();

    // Taken branch with no delay slot yet: wait for it
    push1(32'h3104);
    cyc(0, 0, 1, 1, 0, 0, 32'h5000);
    chk("wds_fr0", last_fr, 0);
    repeat (3) idle();
    push1(32'h3108);
    chk("wds_fr", last_fr, 1);
    chk("wds_rt", last_rt, 32'h5000);
    chk("wds_head", out_PC4, 32'h3108);
    chk("wds_bd", out_BD, 1);
    pop1();

    // Branch-likely nullification, slot queued and slot pending
    push1(32'h3204); push1(32'h3208); push1(32'h320C);
    cyc(0, 0, 1, 0, 1, 0, 0);
    chk("nl_head", out_PC4, 32'h320C);
    chk("nl_bd", out_BD, 0);
    chk("nl_count", count, 1);
    chk("nl_fr", last_fr, 0);
    pop1();
    push1(32'h3304);
    cyc(0, 0, 1, 0, 1, 0, 0);
    push1(32'h3308);
    push1(32'h330C);
    chk("wnl_count", count, 1);
    chk("wnl_head", out_PC4, 32'h330C);
    pop1();

    // Flush beats push and pop+branch
    push1(32'h3404); push1(32'h3408); push1(32'h340C);
    cyc(1, 32'h3410, 1, 1, 0, 1, 32'h7000);
    chk("fl_fr", last_fr, 0);
    chk("fl_count", count, 0);
    push1(32'h3414);
    chk("fl_bd", out_BD, 0);
    pop1();

    // Branch whose slot arrives in the same cycle; nullify with younger push
    push1(32'h3504);
    cyc(1, 32'h3508, 1, 1, 0, 0, 32'h8000);
    chk("brp_bd", out_BD, 1);
    push1(32'h350C); push1(32'h3510);
    cyc(1, 32'h3514, 1, 0, 1, 0, 0);
    chk("nlp_head", out_PC4, 32'h3510);
    repeat (3) pop1();

    // Asynchronous reset while waiting for a delay slot
    push1(32'h3604);
    cyc(0, 0, 1, 1, 0, 0, 32'h6000);
    @(negedge clk); in_valid = 0; out_ready = 0; branch_taken = 0;
    #2 reset = 0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_fr", fetch_redirect, 0);
    chk("ar_bd", out_BD, 0);
    q.delete(); mst = 0; mtgt = 0;
    @(negedge clk); reset = 1;
    push1(32'h3608);
    chk("ar_push_fr", last_fr, 0);
    chk("ar_push_bd", out_BD, 0);
    pop1();

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 19) == 0, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
